// File: rtl/softmax_pkg.sv
// Shared constants and drain FSM state type for the softmax psum read-back path.
package softmax_pkg;
  localparam int unsigned BW          = 8;
  localparam int unsigned SOFTMAX_COL = 8;
  localparam int unsigned RW          = BW * SOFTMAX_COL;
  localparam int unsigned AW          = 6;
  localparam int unsigned MAX_ROWS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_e;
endpackage

// File: rtl/softmax_drain_fifo.sv
// Small output buffer for drained psum rows: synchronous push/pop, head is the oldest entry.
module softmax_drain_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  input  logic                   pop,
  output logic [width-1:0]       head,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(depth));
  assign empty = (count == '0);
endmodule

// File: rtl/softmax_psum_drain.sv
// Walks N consecutive psum rows, reads each once and streams them out with a last flag.
module softmax_psum_drain
  import softmax_pkg::*;
#(
  parameter int unsigned bw          = BW,
  parameter int unsigned softmax_col = SOFTMAX_COL,
  parameter int unsigned aw          = AW,
  parameter int unsigned fifo_depth  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [aw-1:0]             base_add,
  input  logic [3:0]                num_rows,
  output logic                      mem_rd,
  output logic [aw-1:0]             mem_add,
  input  logic [bw*softmax_col-1:0] mem_rdata,
  output logic [bw*softmax_col-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);
  localparam int unsigned CW   = $clog2(fifo_depth) + 1;
  localparam int unsigned CNTW = $clog2(MAX_ROWS) + 1;

  drain_state_e    state;
  logic [aw-1:0]   base_r;
  logic [CNTW-1:0] num_r;
  logic [CNTW-1:0] issued;
  logic [CNTW-1:0] sent;
  logic            inflight;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            credit_ok;
  logic [CW:0]     occ;

  softmax_drain_fifo #(
    .width (bw*softmax_col),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (sent == num_r - CNTW'(1));

  // Credit counts the same-cycle pop as freed space; without it a 2-entry
  // buffer cannot sustain one row per cycle with the read latency in the loop.
  assign occ       = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit_ok = !(fifo_full && !pop) && (occ < (CW+1)'(fifo_depth));

  assign mem_rd  = (state == READ) && credit_ok;
  assign mem_add = base_r + aw'(issued);
  assign busy    = (state == READ) || (state == FLUSH);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      base_r   <= '0;
      num_r    <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd;
      if (mem_rd) issued <= issued + 1'b1;
      if (pop)    sent   <= sent + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base_add;
            num_r  <= num_rows;
            issued <= '0;
            sent   <= '0;
            state  <= (num_rows == '0) ? DONE : READ;
          end
        end
        READ:  if (mem_rd && issued == num_r - CNTW'(1)) state <= FLUSH;
        FLUSH: if (pop && out_last) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_psum_drain.sv
// Randomized scoreboard bench for softmax_psum_drain with a behavioural psum memory.
module tb_softmax_psum_drain;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  base_add;
  logic [3:0]  num_rows;
  logic        mem_rd;
  logic [5:0]  mem_add;
  logic [63:0] mem_rdata;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  softmax_psum_drain #(.bw(8), .softmax_col(8), .aw(6), .fifo_depth(2)) dut (
    .clk(clk), .reset(reset), .start(start), .base_add(base_add), .num_rows(num_rows),
    .mem_rd(mem_rd), .mem_add(mem_add), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  int          addr_q[$];
  logic [63:0] mem [64];
  logic [511:0] predict;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_rd = 0, n_acc = 0;
  int first_rd, last_rd, first_val, last_acc, done_cyc;
  int ready_mode = 0;
  int pat_i = 0;
  logic [3:0] ready_pat = 4'b1001;

  logic       rd_p = 1'b0;
  logic [5:0] ad_p = '0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Memory answers one cycle after the strobe; junk otherwise.
  always @(negedge clk) begin
    rd_p <= mem_rd;
    ad_p <= mem_add;
  end
  always @(posedge clk) mem_rdata <= rd_p ? mem[ad_p] : {$urandom, $urandom};

  always @(posedge clk) begin
    #1;
    pat_i++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ready_pat[pat_i % 4];
      default: out_ready = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        check("busy_during_read", busy, 1);
        if (addr_q.size() == 0) check("unexpected_mem_rd", 1, 0);
        else check("mem_add", mem_add, addr_q.pop_front());
      end
      if (out_valid) begin
        if (first_val < 0) first_val = cyc;
        if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          check("out_data", out_data, exp_q[0].data);
          check("out_last", out_last, exp_q[0].last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_acc++;
            last_acc = cyc;
          end
        end
      end
      if (mem_rd) check("fifo_occupancy_le_depth", (n_rd - n_acc) <= 2, 1);
    end
  end

  task automatic pulse_start(input int base, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_add = 6'(base); num_rows = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expect_burst(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      int a;
      a = (base + k) % 64;
      addr_q.push_back(a);
      exp_q.push_back('{mem[a], (k == n - 1)});
    end
  endtask

  task automatic run_burst(input int base, input int n, input int mode, input bit busy_start);
    bit got;
    ready_mode = mode;
    first_rd = -1; last_rd = -1; first_val = -1; last_acc = -1; done_cyc = -1;
    expect_burst(base, n);
    pulse_start(base, n);
    if (busy_start) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; base_add = 6'd40; num_rows = 4'd3;
      @(posedge clk); #1; start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; done_cyc = cyc; end
    end
    check("done_seen", got, 1);
    if (got) begin
      check("busy_low_in_done", busy, 0);
      check("rows_remaining", exp_q.size(), 0);
      check("reads_remaining", addr_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
    end
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    bit ok;
    int acc0;
    reset = 1'b0; start = 1'b0; base_add = '0; num_rows = '0; out_ready = 1'b1;
    first_rd = -1; last_rd = -1; first_val = -1; last_acc = -1; done_cyc = -1;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    #23;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_add", mem_add, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Single row: latency and done timing.
    run_burst(0, 1, 0, 0);
    check("single_read_count", last_rd - first_rd, 0);
    check("single_first_word_latency", first_val - first_rd, 2);
    check("single_done_after_accept", done_cyc - last_acc, 1);

    // GSA block: rows are 64-bit slices of an 8x8 predict.
    for (int k = 0; k < 16; k++) predict[32*k +: 32] = $urandom;
    for (int k = 0; k < 8; k++) mem[k] = predict[64*k +: 64];
    run_burst(0, 8, 0, 0);
    check("gsa_reads_back_to_back", last_rd - first_rd, 7);
    check("gsa_beats_back_to_back", last_acc - first_val, 7);

    run_burst(0, 8, 1, 0);       // 1,0,0,1 backpressure
    run_burst(62, 4, 2, 0);      // address wrap
    run_burst(5, 0, 0, 0);       // empty burst
    check("n0_no_reads", first_rd, -1);
    run_burst(10, 5, 1, 1);      // start while busy ignored

    // Reset in the middle of a burst.
    ready_mode = 0;
    first_rd = -1; first_val = -1;
    expect_burst(20, 8);
    acc0 = n_acc;
    pulse_start(20, 8);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (n_acc - acc0 >= 3) ok = 1'b1;
    end
    check("midburst_beats_seen", ok, 1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    check("async_rst_mem_rd", mem_rd, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_last", out_last, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    exp_q.delete(); addr_q.delete();
    n_rd = 0; n_acc = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    run_burst(20, 8, 2, 0);

    for (int t = 0; t < 6; t++)
      run_burst(int'($urandom_range(0, 63)), int'($urandom_range(1, 8)), 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
